if_id_queue: RTL
================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, queue entries (power of two, >=2).
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013, instruction presented when empty or flushed.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  discard all entries (taken branch/jump from pc_sel path).
REQ-006 SHALL have port in_valid  input  1  fetch presents a valid instruction.
REQ-007 SHALL have port in_ready  output  1  queue accepts this cycle.
REQ-008 SHALL have ports in_instruction, in_pc, in_pc_4  input  `REG_RANGE each  fetched word, its PC, PC+4.
REQ-009 SHALL have port out_valid  output  1  head entry valid to decode.
REQ-010 SHALL have port out_ready  input  1  decode consumes head (deasserted on decode stall).
REQ-011 SHALL have ports out_instruction, out_pc, out_pc_4  output  `REG_RANGE each  head entry fields.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-013 Enqueue SHALL occur on a cycle with in_valid && in_ready && !flush; dequeue SHALL occur on out_valid && out_ready && !flush.
REQ-014 in_ready SHALL equal (count != DEPTH), combinational from registered count only; no full-bypass (full + dequeue same cycle still reports in_ready=0).
REQ-015 out_valid SHALL equal (count != 0); no empty-bypass: an entry enqueued at edge N is visible at the outputs after edge N, never combinationally in the same cycle.
REQ-016 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-017 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH without extra logic.
REQ-018 When out_valid=0, out_instruction SHALL be NOP_INST and out_pc/out_pc_4 SHALL be 0.
REQ-019 flush SHALL, at the next edge, set count=0 and both pointers to 0; flush has priority over enqueue and dequeue in the same cycle.
REQ-020 Entries SHALL be presented strictly in enqueue order; an entry SHALL never be duplicated or dropped except by flush.
REQ-021 out_* SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-022 reset low SHALL immediately force count=0, pointers=0, out_valid=0, in_ready=1, out_instruction=NOP_INST, out_pc=0, out_pc_4=0, regardless of clk.
REQ-023 Reset asserted mid-operation SHALL discard all entries; first enqueue after release behaves as from empty.
REQ-024 Storage array contents need no reset.

Configuration
REQ-025 Macro IF_ID_QUEUE_PERF_EN SHALL, when defined, add output stall_cycles  32 bits, counting cycles with out_valid=1 && out_ready=0, plus output bubble_cycles  32 bits, counting cycles with out_valid=0 && !flush; both saturate at 32'hFFFF_FFFF, clear on reset, are unaffected by flush.
REQ-026 Without IF_ID_QUEUE_PERF_EN those ports and counters SHALL not exist; remaining behaviour identical.

Structure
REQ-027 Entry typedef if_id_entry_t {instruction, pc, pc_4} and NOP constant SHALL live in the shared instruction definitions package alongside REG_RANGE.
REQ-028 Saturating counter SHALL be sub-module sat_counter, instantiated twice only under IF_ID_QUEUE_PERF_EN; queue control stays in if_id_queue.

Verification
REQ-029 Reset then idle -> out_valid=0, in_ready=1, count=0, out_instruction=32'h0000_0013.
REQ-030 Enqueue 0x00500093@pc 0x0 with out_ready=0 -> next cycle out_valid=1, out_instruction=0x00500093, out_pc=0x0, out_pc_4=0x4, count=1.
REQ-031 Enqueue two words, out_ready=0 -> count=2, in_ready=0; third in_valid held -> not accepted; raise out_ready -> words emerge in order pc 0x0, 0x4, then 0x8.
REQ-032 Full queue, flush=1 with in_valid=1 and out_ready=1 same cycle -> next cycle count=0, out_valid=0, out_instruction=NOP; flushed-cycle input not stored.
REQ-033 Continuous in_valid and out_ready for 16 cycles, PCs 0x0..0x3C -> count stays 1 after fill, outputs all 16 PCs in order across pointer wrap.
REQ-034 With IF_ID_QUEUE_PERF_EN: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cycles=5; assert reset low mid-sequence -> counters and count return to 0 asynchronously.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared instruction definitions for the IF/ID queue: register range, NOP encoding
// and the entry record carried from fetch to decode.
`ifndef REG_RANGE
`define REG_RANGE 31:0
`endif

package if_id_queue_pkg;

    localparam logic [`REG_RANGE] NOP_INST_DEF = 32'h0000_0013;

    typedef struct packed {
        logic [`REG_RANGE] instruction;
        logic [`REG_RANGE] pc;
        logic [`REG_RANGE] pc_4;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_queue_sat_counter.sv
// Saturating event counter with asynchronous active-low clear; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign count = r_cnt;

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue without full/empty bypass; flush empties it.
// Define IF_ID_QUEUE_PERF_EN to add saturating stall/bubble cycle counters.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [`REG_RANGE] NOP_INST = NOP_INST_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [`REG_RANGE]          in_instruction,
    input  logic [`REG_RANGE]          in_pc,
    input  logic [`REG_RANGE]          in_pc_4,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [`REG_RANGE]          out_instruction,
    output logic [`REG_RANGE]          out_pc,
    output logic [`REG_RANGE]          out_pc_4,
    output logic [$clog2(DEPTH):0]     count
`ifdef IF_ID_QUEUE_PERF_EN
    ,
    output logic [31:0]                stall_cycles,
    output logic [31:0]                bubble_cycles
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if_id_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_enq;
    logic          w_deq;
    if_id_entry_t  w_head;

    assign in_ready  = (r_count != FULL);
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_enq  = in_valid && in_ready && !flush;
    assign w_deq  = out_valid && out_ready && !flush;
    assign w_head = r_mem[r_rptr];

    // Empty queue presents a NOP so decode sees a harmless bubble.
    assign out_instruction = out_valid ? w_head.instruction : NOP_INST;
    assign out_pc          = out_valid ? w_head.pc          : '0;
    assign out_pc_4        = out_valid ? w_head.pc_4        : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_deq) r_rptr <= r_rptr + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wptr] <= '{instruction: in_instruction, pc: in_pc, pc_4: in_pc_4};
        end
    end

`ifdef IF_ID_QUEUE_PERF_EN
    logic w_stall;
    logic w_bubble;

    assign w_stall  = out_valid && !out_ready;
    assign w_bubble = !out_valid && !flush;

    sat_counter #(.W(32)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (w_stall),
        .count (stall_cycles)
    );

    sat_counter #(.W(32)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (w_bubble),
        .count (bubble_cycles)
    );
`endif

endmodule
